// File: rtl/fir_pkg.sv
// Shared constants, derived-width helper and per-stage valid struct for the
// threshold FIR detector family.
package fir_pkg;

  localparam int FIR_TAPS_DEF = 9;
  localparam int FIR_XW_DEF   = 4;
  localparam int FIR_CW_DEF   = 4;

  // One valid bit per pipeline stage; p3 is the registered output stage.
  typedef struct packed {
    logic p3;
    logic p2;
    logic p1;
    logic p0;
  } fir_vld_t;

  // Width that holds TAPS full-scale unsigned products without overflow.
  function automatic int acc_width(input int xw, input int cw, input int taps);
    return xw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, and a
// commit copies the whole shadow bank (pre-write contents) into the active bank.
module fir_coef_bank #(
  parameter int TAPS = 9,
  parameter int CW   = 4,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  input  logic          coef_commit,
  output logic [CW-1:0] c_act [TAPS]
);

  logic [CW-1:0] shadow_q [TAPS];
  logic [CW-1:0] shadow_d [TAPS];
  logic [CW-1:0] active_q [TAPS];
  logic [CW-1:0] active_d [TAPS];
  logic          wr_hit;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    wr_hit   = coef_we && (int'(coef_addr) < TAPS);
    if (wr_hit) begin
      shadow_d[coef_addr] = coef_data;
    end
    // Commit reads shadow_q, so a same-cycle write is not part of the copy.
    if (coef_commit) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign c_act = active_q;

endmodule

// File: rtl/fir_thresh_pipe.sv
// Pipelined N-tap FIR threshold detector, fixed 4-cycle accept-to-output latency.
// Optional hysteresis on the detect flag is enabled by defining FIR_HYST_EN.
module fir_thresh_pipe
  import fir_pkg::*;
#(
  parameter  int TAPS = FIR_TAPS_DEF,
  parameter  int XW   = FIR_XW_DEF,
  parameter  int CW   = FIR_CW_DEF,
  localparam int ACCW = acc_width(XW, CW, TAPS),
  localparam int AW   = $clog2(TAPS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XW-1:0]   x,
  input  logic [ACCW-1:0] thresh,
  input  logic            coef_we,
  input  logic [AW-1:0]   coef_addr,
  input  logic [CW-1:0]   coef_data,
  input  logic            coef_commit,
`ifdef FIR_HYST_EN
  input  logic [ACCW-1:0] hyst,
`endif
  output logic            out_valid,
  output logic            y,
  output logic [ACCW-1:0] sum_out
);

  localparam int PW = XW + CW;

  logic [CW-1:0]   c_act [TAPS];

  fir_vld_t        vld_q, vld_d;
  logic [XW-1:0]   x_sh_q [TAPS];
  logic [XW-1:0]   x_sh_d [TAPS];
  logic [ACCW-1:0] thr_p0_q, thr_p0_d;
  logic [ACCW-1:0] thr_p1_q, thr_p1_d;
  logic [ACCW-1:0] thr_p2_q, thr_p2_d;
  logic [PW-1:0]   prod_p1_q [TAPS];
  logic [PW-1:0]   prod_p1_d [TAPS];
  logic [ACCW-1:0] sum_p2_q, sum_p2_d;
  logic [ACCW-1:0] sum_p3_q, sum_p3_d;
  logic            y_p3_q, y_p3_d;
`ifdef FIR_HYST_EN
  logic [ACCW-1:0] hys_p0_q, hys_p0_d;
  logic [ACCW-1:0] hys_p1_q, hys_p1_d;
  logic [ACCW-1:0] hys_p2_q, hys_p2_d;

  function automatic logic [ACCW-1:0] sat_sub(input logic [ACCW-1:0] a,
                                               input logic [ACCW-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic hyst_detect(input logic [ACCW-1:0] s,
                                       input logic [ACCW-1:0] th,
                                       input logic [ACCW-1:0] hy,
                                       input logic            prev);
    if (s > th) begin
      return 1'b1;
    end else if (s < sat_sub(th, hy)) begin
      return 1'b0;
    end
    return prev;
  endfunction
`endif

  fir_coef_bank #(
    .TAPS (TAPS),
    .CW   (CW),
    .AW   (AW)
  ) u_coef_bank (
    .clk         (clk),
    .rst         (rst),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .c_act       (c_act)
  );

  always_comb begin
    vld_d    = '{p3: vld_q.p2, p2: vld_q.p1, p1: vld_q.p0, p0: in_valid};

    // S0: shift register advances only on accepted samples
    x_sh_d   = x_sh_q;
    thr_p0_d = thr_p0_q;
    if (in_valid) begin
      x_sh_d[0] = x;
      for (int i = 1; i < TAPS; i++) begin
        x_sh_d[i] = x_sh_q[i-1];
      end
      thr_p0_d = thresh;
    end

    // S1: per-tap products against the active bank
    for (int i = 0; i < TAPS; i++) begin
      prod_p1_d[i] = PW'(x_sh_q[i]) * PW'(c_act[i]);
    end
    thr_p1_d = thr_p0_q;

    // S2: reduction
    sum_p2_d = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum_p2_d = sum_p2_d + ACCW'(prod_p1_q[i]);
    end
    thr_p2_d = thr_p1_q;

    // S3: compare; results hold between valid pulses
    sum_p3_d = sum_p3_q;
    y_p3_d   = y_p3_q;
    if (vld_q.p2) begin
      sum_p3_d = sum_p2_q;
`ifdef FIR_HYST_EN
      y_p3_d   = hyst_detect(sum_p2_q, thr_p2_q, hys_p2_q, y_p3_q);
`else
      y_p3_d   = sum_p2_q > thr_p2_q;
`endif
    end
  end

`ifdef FIR_HYST_EN
  always_comb begin
    hys_p0_d = in_valid ? hyst : hys_p0_q;
    hys_p1_d = hys_p0_q;
    hys_p2_d = hys_p1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hys_p0_q <= '0;
      hys_p1_q <= '0;
      hys_p2_q <= '0;
    end else begin
      hys_p0_q <= hys_p0_d;
      hys_p1_q <= hys_p1_d;
      hys_p2_q <= hys_p2_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      thr_p0_q <= '0;
      thr_p1_q <= '0;
      thr_p2_q <= '0;
      sum_p2_q <= '0;
      sum_p3_q <= '0;
      y_p3_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_sh_q[i]    <= '0;
        prod_p1_q[i] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      x_sh_q    <= x_sh_d;
      thr_p0_q  <= thr_p0_d;
      thr_p1_q  <= thr_p1_d;
      thr_p2_q  <= thr_p2_d;
      prod_p1_q <= prod_p1_d;
      sum_p2_q  <= sum_p2_d;
      sum_p3_q  <= sum_p3_d;
      y_p3_q    <= y_p3_d;
    end
  end

  assign out_valid = vld_q.p3;
  assign y         = y_p3_q;
  assign sum_out   = sum_p3_q;

endmodule

// File: tb/tb_fir_thresh_pipe.sv
// Directed and randomized bench for fir_thresh_pipe, checked every cycle
// against a sample-history / coefficient-array model of the detector.
module tb_fir_thresh_pipe;
  import fir_pkg::*;

  localparam int TAPS = 9;
  localparam int XW   = 4;
  localparam int CW   = 4;
  localparam int ACCW = acc_width(XW, CW, TAPS);
  localparam int AW   = $clog2(TAPS);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic [XW-1:0]   x = '0;
  logic [ACCW-1:0] thresh = '0;
  logic            coef_we = 1'b0;
  logic [AW-1:0]   coef_addr = '0;
  logic [CW-1:0]   coef_data = '0;
  logic            coef_commit = 1'b0;
`ifdef FIR_HYST_EN
  logic [ACCW-1:0] hyst = '0;
`endif
  logic            out_valid;
  logic            y;
  logic [ACCW-1:0] sum_out;

  always #5 clk = ~clk;

  fir_thresh_pipe #(.TAPS(TAPS), .XW(XW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .x           (x),
    .thresh      (thresh),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
`ifdef FIR_HYST_EN
    .hyst        (hyst),
`endif
    .out_valid   (out_valid),
    .y           (y),
    .sum_out     (sum_out)
  );

  typedef struct {
    int due;
    int sum;
    int th;
    int hy;
  } exp_t;

  exp_t exp_q[$];
  int   obs_q[$];
  int   m_shadow [TAPS];
  int   m_active [TAPS];
  int   m_hist   [TAPS];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_sum = 0;
  bit   last_y = 1'b0;

  function automatic bit model_y(input int s, input int th, input int hy, input bit prev);
`ifdef FIR_HYST_EN
    int lo;
    lo = (th > hy) ? th - hy : 0;
    if (s > th) return 1'b1;
    if (s < lo) return 1'b0;
    return prev;
`else
    return s > th;
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic check_outputs();
    bit   ev;
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due < edge_n) void'(exp_q.pop_front());
    ev = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
    if (ev) begin
      e        = exp_q.pop_front();
      last_y   = model_y(e.sum, e.th, e.hy, last_y);
      last_sum = e.sum;
    end
    checks++;
    assert (out_valid === ev) else begin
      errors++;
      $error("FAIL out_valid @edge %0d: got %b want %b", edge_n, out_valid, ev);
    end
    checks++;
    assert (sum_out === last_sum[ACCW-1:0]) else begin
      errors++;
      $error("FAIL sum_out @edge %0d: got %0d want %0d", edge_n, sum_out, last_sum);
    end
    checks++;
    assert (y === last_y) else begin
      errors++;
      $error("FAIL y @edge %0d: got %b want %b", edge_n, y, last_y);
    end
    if (out_valid === 1'b1) obs_q.push_back(int'(sum_out));
  endtask

  task automatic tick();
    int   nact [TAPS];
    int   s;
    exp_t e;
    @(posedge clk);
    edge_n++;
    if (!rst) begin
      nact = coef_commit ? m_shadow : m_active;
      if (in_valid) begin
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int'(x);
        s = 0;
        for (int i = 0; i < TAPS; i++) s += m_hist[i] * nact[i];
        e.due = edge_n + 3;
        e.sum = s;
        e.th  = int'(thresh);
`ifdef FIR_HYST_EN
        e.hy  = int'(hyst);
`else
        e.hy  = 0;
`endif
        exp_q.push_back(e);
      end
      m_active = nact;
      if (coef_we && int'(coef_addr) < TAPS) m_shadow[coef_addr] = int'(coef_data);
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    exp_q.delete();
    for (int i = 0; i < TAPS; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
      m_hist[i]   = 0;
    end
    last_sum = 0;
    last_y   = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_sum_out", int'(sum_out), 0);
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic clr_ctl();
    in_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;
  endtask

  task automatic send(input int xv, input int th);
    in_valid = 1'b1;
    x        = xv[XW-1:0];
    thresh   = th[ACCW-1:0];
    tick();
    clr_ctl();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = a[AW-1:0];
    coef_data = d[CW-1:0];
    tick();
    clr_ctl();
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    tick();
    clr_ctl();
  endtask

  initial begin
    do_reset(3);

    // Zero coefficients: output is zero, not detected
    obs_q.delete();
    send(15, 0);
    idle(5);
    chk("zero_coef_count", obs_q.size(), 1);
    chk("zero_coef_sum", int'(sum_out), 0);

    // Full-scale: 9 * 15 * 15 = 2025
    for (int i = 0; i < TAPS; i++) wr_coef(i, 15);
    commit();
    repeat (9) send(15, 2000);
    idle(4);
    chk("full_sum", int'(sum_out), 2025);
    chk("full_y_gt", int'(y), 1);
    repeat (9) send(15, 2025);
    idle(4);
    chk("full_sum_eq", int'(sum_out), 2025);
    chk("full_y_eq", int'(y), 0);

    // Impulse response with c[i] = i+1
    for (int i = 0; i < TAPS; i++) wr_coef(i, i + 1);
    commit();
    repeat (9) send(0, 0);
    idle(4);
    obs_q.delete();
    send(1, 0);
    repeat (9) send(0, 0);
    idle(4);
    chk("imp_count", obs_q.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("imp_seq", (i < obs_q.size()) ? obs_q[i] : -1, (i < 9) ? i + 1 : 0);

    // Same impulse with bubbles between accepts
    obs_q.delete();
    send(1, 0);
    idle($urandom_range(1, 3));
    repeat (9) begin
      send(0, 0);
      idle($urandom_range(0, 3));
    end
    idle(4);
    chk("bub_count", obs_q.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("bub_seq", (i < obs_q.size()) ? obs_q[i] : -1, (i < 9) ? i + 1 : 0);

    // Commit boundary: old set all 2, new set all 1, x = 1
    for (int i = 0; i < TAPS; i++) wr_coef(i, 2);
    commit();
    repeat (9) send(1, 0);
    for (int i = 0; i < TAPS; i++) wr_coef(i, 1);
    idle(4);
    obs_q.delete();
    send(1, 0);
    coef_commit = 1'b1;
    send(1, 0);
    idle(4);
    chk("commit_old", (obs_q.size() > 0) ? obs_q[0] : -1, 18);
    chk("commit_new", (obs_q.size() > 1) ? obs_q[1] : -1, 9);

    // Same-cycle write and commit: active c[0] keeps the old shadow value
    repeat (9) send(0, 0);
    coef_we = 1'b1; coef_addr = '0; coef_data = CW'(7); coef_commit = 1'b1;
    tick();
    clr_ctl();
    idle(4);
    obs_q.delete();
    send(1, 0);
    idle(4);
    chk("wr_commit_c0", (obs_q.size() > 0) ? obs_q[0] : -1, 1);

`ifndef FIR_HYST_EN
    // Sum 90 against 100 without hysteresis is not a detect
    repeat (9) send(10, 100);
    idle(4);
    chk("sum90", int'(sum_out), 90);
    chk("sum90_y", int'(y), 0);
`endif

    // Reset with samples in flight
    send(3, 0);
    send(4, 0);
    send(5, 0);
    do_reset(2);
    idle(6);
    send(5, 0);
    idle(4);

    // Randomized traffic including coefficient updates
    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      x           = XW'($urandom);
      thresh      = ACCW'($urandom_range(0, 2100));
      coef_we     = ($urandom_range(0, 7) == 0);
      coef_addr   = AW'($urandom_range(0, (1 << AW) - 1));
      coef_data   = CW'($urandom);
      coef_commit = ($urandom_range(0, 15) == 0);
`ifdef FIR_HYST_EN
      hyst        = ACCW'($urandom_range(0, 300));
`endif
      tick();
      clr_ctl();
      if (n == 200) do_reset(1);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
